// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 byte transmitter: inhibit, request-to-send, 11-bit frame on device clock, ack/timeout report.
// Optional `PS2_TX_RETRY_EN: one silent restart from INHIBIT after a NACK or timeout; otherwise the first failure pulses error.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);
    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [7:0]       data_q, data_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             clk_meta_q, clk_sync_q, clk_prev_q;
    logic             dat_meta_q, dat_sync_q;
    logic             clk_fall;
    logic             fail;
`ifdef PS2_TX_RETRY_EN
    logic             retry_q, retry_d;
`endif

    // Idle bus level is high, so the synchronizers reset to 1 to avoid a phantom fall.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_meta_q <= ps2_clk_in;
            clk_sync_q <= clk_meta_q;
            clk_prev_q <= clk_sync_q;
            dat_meta_q <= ps2_data_in;
            dat_sync_q <= dat_meta_q;
        end
    end

    assign clk_fall = clk_prev_q & ~clk_sync_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        data_d    = data_q;
        data_oe_d = data_oe_q;
        clk_oe_d  = 1'b0;
        done_d    = 1'b0;
        error_d   = 1'b0;
        fail      = 1'b0;
`ifdef PS2_TX_RETRY_EN
        retry_d   = retry_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (tx_valid) begin
                    data_d  = tx_data;
                    cnt_d   = '0;
                    state_d = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
                    retry_d = 1'b0;
`endif
                end
            end
            S_INHIBIT: begin
                if (cnt_q == INH_LAST) state_d = S_RTS;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            S_RTS: begin
                state_d = S_SEND;
                cnt_d   = '0;
                bit_d   = '0;
            end
            S_SEND: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == TMO_LAST) begin
                    fail = 1'b1;
                end else if (clk_fall) begin
                    bit_d = bit_q + 1'b1;
                    if (bit_q == 4'd9) begin
                        data_oe_d = 1'b0;
                        state_d   = S_ACK;
                    end else if (bit_q == 4'd8) begin
                        data_oe_d = ^data_q;
                    end else begin
                        data_oe_d = ~data_q[bit_q[2:0]];
                    end
                end
            end
            S_ACK: begin
                cnt_d = cnt_q + 1'b1;
                // A device fall on the timeout cycle still delivers its ack result.
                if (clk_fall) begin
                    state_d = S_WAIT_IDLE;
                    if (!dat_sync_q) done_d = 1'b1;
                    else             fail   = 1'b1;
                end else if (cnt_q == TMO_LAST) begin
                    fail = 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                if (clk_sync_q && dat_sync_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (fail) begin
`ifdef PS2_TX_RETRY_EN
            if (!retry_q) begin
                retry_d = 1'b1;
                cnt_d   = '0;
                state_d = S_INHIBIT;
            end else begin
                error_d = 1'b1;
                state_d = S_WAIT_IDLE;
            end
`else
            error_d = 1'b1;
            state_d = S_WAIT_IDLE;
`endif
        end

        // Line drivers are registered from the next state so they never glitch.
        clk_oe_d = (state_d == S_INHIBIT) || (state_d == S_RTS);
        if (state_d == S_RTS)       data_oe_d = 1'b1;
        else if (state_d != S_SEND) data_oe_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            data_q    <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            data_q    <= data_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

`ifdef PS2_TX_RETRY_EN
    always_ff @(posedge clk) begin
        if (reset) retry_q <= 1'b0;
        else       retry_q <= retry_d;
    end
`endif

    assign tx_ready    = (state_q == S_IDLE);
    assign busy        = ~tx_ready;
    assign done        = done_q;
    assign error       = error_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule
